// File: rtl/cnt_pkg.sv
// Shared constants and the BCD-to-7-segment decode for the push-button
// BCD counter.
//   BCD_W     : width of one BCD digit
//   FND_W     : width of one 7-segment digit, {g,f,e,d,c,b,a}
//   FND_BLANK : pattern shown for a non-BCD digit value
package cnt_pkg;
  localparam int         BCD_W     = 4;
  localparam int         FND_W     = 7;
  localparam logic [6:0] FND_BLANK = 7'h00;

  // Active-high segments; anything above 9 shows blank.
  function automatic logic [FND_W-1:0] bcd_to_fnd(input logic [BCD_W-1:0] d);
    logic [FND_W-1:0] seg;
    case (d)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = FND_BLANK;
    endcase
    return seg;
  endfunction
endpackage

// File: rtl/push_debounce.sv
// Two-flop synchroniser plus debounce for one active-low push button.
//   i_Clk   : clock
//   i_Rst   : async active-low reset
//   i_Raw   : raw asynchronous button, active-low
//   o_Level : debounced stable level (1 = released)
//   o_Fall  : one-cycle pulse when the stable level goes 1->0 (press)
module push_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Fall
);
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  // Marks when sync_q[1] holds a real sample rather than its reset value.
  logic [1:0]    vld_q, vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  // Armed only after the button has been seen released (debounced) since
  // reset, so a button held through reset cannot fire an event.
  logic          arm_q, arm_d;
  logic          ref_lvl, differ;

  always_comb begin
    sync_d  = {sync_q[0], i_Raw};
    vld_d   = {vld_q[0], 1'b1};
    // While unarmed, compare against "pressed" so a sustained high sample
    // is what gets debounced and arms the button.
    ref_lvl = arm_q ? level_q : 1'b0;
    differ  = vld_q[1] && (sync_q[1] != ref_lvl);
    cnt_d   = '0;
    level_d = level_q;
    arm_d   = arm_q;
    fall_d  = 1'b0;
    if (differ) begin
      if (cnt_q == LAST) begin
        if (arm_q) begin
          level_d = sync_q[1];
          fall_d  = level_q & ~sync_q[1];
        end else begin
          arm_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      sync_q  <= 2'b11;
      vld_q   <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      arm_q   <= arm_d;
    end
  end

  assign o_Level = level_q;
  assign o_Fall  = fall_q;
endmodule

// File: rtl/bcd_updown_counter.sv
// DIGITS-digit BCD up/down counter driven by two debounced push buttons,
// with synchronous clamped load and wrap/saturate selection.
//   i_Clk, i_Rst : clock, async active-low reset
//   i_Push       : raw buttons, active-low; [1] up, [0] down
//   i_Load       : load strobe (highest priority), i_LoadVal BCD value
//   i_Sat        : 1 = saturate at 0 / all-9s, 0 = wrap
//   o_Cnt        : BCD count; o_Carry/o_Borrow wrap pulses
//   o_FND        : 7-segment pattern per digit
module bcd_updown_counter
  import cnt_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int DB_CYCLES = 50000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [1:0]              i_Push,
  input  logic                    i_Load,
  input  logic [BCD_W*DIGITS-1:0] i_LoadVal,
  input  logic                    i_Sat,
  output logic [BCD_W*DIGITS-1:0] o_Cnt,
  output logic                    o_Carry,
  output logic                    o_Borrow,
  output logic [FND_W*DIGITS-1:0] o_FND
);
  logic [1:0] unused_lvl;
  logic       up_ev, dn_ev;

  push_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Push[1]),
    .o_Level(unused_lvl[1]), .o_Fall(up_ev)
  );
  push_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Raw(i_Push[0]),
    .o_Level(unused_lvl[0]), .o_Fall(dn_ev)
  );

  logic [DIGITS-1:0][BCD_W-1:0] cnt_q, cnt_d, inc_v, dec_v, ld_v;
  logic [DIGITS:0]              inc_c, dec_b;
  logic                         carry_q, carry_d, borrow_q, borrow_d;
  logic                         at_max, at_min;

  assign inc_c[0] = 1'b1;
  assign dec_b[0] = 1'b1;

  // Per-digit ripple: a digit steps only when every lower digit rolls over.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic [BCD_W-1:0] ld_raw;
    assign ld_raw     = i_LoadVal[k*BCD_W +: BCD_W];
    assign ld_v[k]    = (ld_raw > 4'd9) ? 4'd9 : ld_raw;
    assign inc_v[k]   = !inc_c[k] ? cnt_q[k] :
                        (cnt_q[k] == 4'd9) ? 4'd0 : cnt_q[k] + 4'd1;
    assign dec_v[k]   = !dec_b[k] ? cnt_q[k] :
                        (cnt_q[k] == 4'd0) ? 4'd9 : cnt_q[k] - 4'd1;
    assign inc_c[k+1] = inc_c[k] & (cnt_q[k] == 4'd9);
    assign dec_b[k+1] = dec_b[k] & (cnt_q[k] == 4'd0);
    assign o_FND[k*FND_W +: FND_W] = bcd_to_fnd(cnt_q[k]);
  end

  // Ripple out of the top digit means the count sits at a bound; the
  // rippled value is already the wrapped value.
  assign at_max = inc_c[DIGITS];
  assign at_min = dec_b[DIGITS];

  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (i_Load) begin
      cnt_d = ld_v;
    end else if (up_ev && !dn_ev) begin
      if (!(at_max && i_Sat)) begin
        cnt_d   = inc_v;
        carry_d = at_max;
      end
    end else if (dn_ev && !up_ev) begin
      if (!(at_min && i_Sat)) begin
        cnt_d    = dec_v;
        borrow_d = at_min;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign o_Cnt    = cnt_q;
  assign o_Carry  = carry_q;
  assign o_Borrow = borrow_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;
  localparam int DIGITS = 2;
  localparam int DB     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  push;
  logic        load;
  logic [7:0]  load_val;
  logic        sat;
  logic [7:0]  cnt;
  logic        carry, borrow;
  logic [13:0] fnd;

  int n_chk = 0, n_fail = 0;
  int carry_seen = 0, borrow_seen = 0;
  logic [7:0] exp_q[$];

  bcd_updown_counter #(.DIGITS(DIGITS), .DB_CYCLES(DB)) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_Push(push), .i_Load(load),
    .i_LoadVal(load_val), .i_Sat(sat), .o_Cnt(cnt), .o_Carry(carry),
    .o_Borrow(borrow), .o_FND(fnd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (carry)  carry_seen++;
    if (borrow) borrow_seen++;
  end

  typedef struct {
    logic [7:0]  ld;
    logic [7:0]  exp_cnt;
    logic [13:0] exp_fnd;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_load(input string nm, input logic [7:0] v,
                         input logic [7:0] e, input logic [13:0] ef);
    exp_q.push_back(e);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
    chk({nm, "_cnt"}, cnt, exp_q.pop_front());
    chk({nm, "_fnd"}, fnd, ef);
    chk({nm, "_pulse"}, {carry, borrow}, 2'b00);
  endtask

  // Press button idx, expect count to hold for 6 edges then change on the
  // 7th (2 sync + DB debounce + 1 update), then release and settle.
  task automatic press_check(input string nm, input int idx, input logic [7:0] prev,
                             input logic [7:0] e, input logic ec, input logic eb);
    exp_q.push_back(e);
    push[idx] = 1'b0;
    repeat (6) tick();
    chk({nm, "_early"}, cnt, prev);
    tick();
    chk({nm, "_cnt"}, cnt, exp_q.pop_front());
    chk({nm, "_pulse"}, {carry, borrow}, {ec, eb});
    tick();
    chk({nm, "_pulse_end"}, {carry, borrow}, 2'b00);
    repeat (4) tick();
    chk({nm, "_held"}, cnt, e);
    push[idx] = 1'b1;
    repeat (10) tick();
  endtask

  vec_t vecs[5];
  int c0, b0;

  initial begin
    vecs[0] = '{8'h42, 8'h42, {7'h66, 7'h5B}};
    vecs[1] = '{8'hA7, 8'h97, {7'h6F, 7'h07}};
    vecs[2] = '{8'hFF, 8'h99, {7'h6F, 7'h6F}};
    vecs[3] = '{8'h05, 8'h05, {7'h3F, 7'h6D}};
    vecs[4] = '{8'h38, 8'h38, {7'h4F, 7'h7F}};

    rst_n = 1'b1; push = 2'b11; load = 1'b0; load_val = '0; sat = 1'b0;
    #1 rst_n = 1'b0;
    #10;
    chk("reset_cnt", cnt, 8'h00);
    chk("reset_pulse", {carry, borrow}, 2'b00);
    chk("reset_fnd", fnd, {7'h3F, 7'h3F});
    #11 rst_n = 1'b1;
    repeat (10) tick();

    // single press
    press_check("up1", 1, 8'h00, 8'h01, 1'b0, 1'b0);
    chk("up1_fnd", fnd[6:0], 7'h06);

    // glitch of 3 cycles on down
    c0 = carry_seen; b0 = borrow_seen;
    push[0] = 1'b0;
    repeat (3) tick();
    push[0] = 1'b1;
    repeat (12) tick();
    chk("glitch_cnt", cnt, 8'h01);
    chk("glitch_pulses", carry_seen + borrow_seen, c0 + b0);

    // load table with clamp and decode
    for (int i = 0; i < 5; i++)
      do_load($sformatf("load%0d", i), vecs[i].ld, vecs[i].exp_cnt, vecs[i].exp_fnd);

    // wrap mode
    sat = 1'b0;
    do_load("wrap_ld", 8'h99, 8'h99, {7'h6F, 7'h6F});
    c0 = carry_seen;
    press_check("wrap_up", 1, 8'h99, 8'h00, 1'b1, 1'b0);
    chk("wrap_carry_len", carry_seen - c0, 1);
    b0 = borrow_seen;
    press_check("wrap_dn", 0, 8'h00, 8'h99, 1'b0, 1'b1);
    chk("wrap_borrow_len", borrow_seen - b0, 1);

    // saturate mode
    sat = 1'b1;
    do_load("sat_ld9", 8'h99, 8'h99, {7'h6F, 7'h6F});
    press_check("sat_up", 1, 8'h99, 8'h99, 1'b0, 1'b0);
    do_load("sat_ld0", 8'h00, 8'h00, {7'h3F, 7'h3F});
    press_check("sat_dn", 0, 8'h00, 8'h00, 1'b0, 1'b0);
    sat = 1'b0;

    // load beats an up event in the same cycle
    do_load("pri_ld", 8'h12, 8'h12, {7'h06, 7'h5B});
    push[1] = 1'b0;
    repeat (6) tick();
    exp_q.push_back(8'h97);
    load = 1'b1; load_val = 8'hA7;
    tick();
    load = 1'b0;
    chk("pri_load_cnt", cnt, exp_q.pop_front());
    repeat (4) tick();
    chk("pri_no_inc", cnt, 8'h97);
    push[1] = 1'b1;
    repeat (10) tick();

    // simultaneous up and down
    do_load("sim_ld", 8'h19, 8'h19, {7'h06, 7'h6F});
    c0 = carry_seen; b0 = borrow_seen;
    push = 2'b00;
    repeat (8) tick();
    chk("sim_cnt", cnt, 8'h19);
    push = 2'b11;
    repeat (10) tick();
    chk("sim_cnt_after", cnt, 8'h19);
    chk("sim_pulses", carry_seen + borrow_seen, c0 + b0);

    // digit ripple
    press_check("rip_up", 1, 8'h19, 8'h20, 1'b0, 1'b0);
    press_check("rip_dn", 0, 8'h20, 8'h19, 1'b0, 1'b0);
    press_check("rip_up2", 1, 8'h19, 8'h20, 1'b0, 1'b0);

    // reset while up is held
    push[1] = 1'b0;
    repeat (8) tick();
    chk("mid_pre", cnt, 8'h21);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", cnt, 8'h00);
    chk("mid_rst_fnd", fnd, {7'h3F, 7'h3F});
    #2 rst_n = 1'b1;
    repeat (20) tick();
    chk("mid_held_no_ev", cnt, 8'h00);
    push[1] = 1'b1;
    repeat (12) tick();
    chk("mid_release_no_ev", cnt, 8'h00);
    press_check("mid_repress", 1, 8'h00, 8'h01, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
